// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream
//   Converts an AXI-Stream of 24-bit RGB pixels into 8-bit luma,
//   Y = (KR*R + KG*G + KB*B) >> 8, using a two-stage pipeline with full valid/ready
//   backpressure. Output pixels are counted per line and per frame. Each pixel is flagged
//   with end-of-line and end-of-frame, and a one-cycle frame_done pulse follows the last
//   pixel of every frame.
//
//   Build option: define RGB2GRAY_ROUND_EN to add 128 before the shift, which rounds to
//   nearest. When it is undefined the result is truncated.
//
// Ports
//   axi_clk       in   clock, rising edge
//   axi_rst_n     in   asynchronous reset, active low
//   s_rgb_valid   in   input pixel valid
//   s_rgb_data    in   {R[23:16], G[15:8], B[7:0]}
//   s_rgb_ready   out  stage accepts input
//   m_gray_valid  out  luma pixel valid
//   m_gray_data   out  luma pixel
//   m_gray_ready  in   downstream ready
//   m_gray_eol    out  last pixel of a line
//   m_gray_last   out  last pixel of the frame
//   frame_done    out  one-cycle pulse after the last pixel of a frame is handshaken
module rgb_to_gray_stream #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned KR         = 77,
  parameter int unsigned KG         = 150,
  parameter int unsigned KB         = 29
) (
  input  logic        axi_clk,
  input  logic        axi_rst_n,
  input  logic        s_rgb_valid,
  input  logic [23:0] s_rgb_data,
  output logic        s_rgb_ready,
  output logic        m_gray_valid,
  output logic [7:0]  m_gray_data,
  input  logic        m_gray_ready,
  output logic        m_gray_eol,
  output logic        m_gray_last,
  output logic        frame_done
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_HEIGHT - 1);
  localparam logic [15:0] KrC = 16'(KR[7:0]);
  localparam logic [15:0] KgC = 16'(KG[7:0]);
  localparam logic [15:0] KbC = 16'(KB[7:0]);
`ifdef RGB2GRAY_ROUND_EN
  localparam logic [17:0] RoundBias = 18'd128;
`else
  localparam logic [17:0] RoundBias = 18'd0;
`endif

  // The whole pipeline moves together whenever the output slot is free or being drained.
  logic adv;
  logic out_hs;

  // Stage 1: per-channel products.
  logic [15:0] pr_d, pg_d, pb_d;
  logic [15:0] pr_q, pg_q, pb_q;
  logic        v1_q;

  // Stage 2: summed, shifted and saturated luma.
  logic [17:0] sum_d;
  logic [17:0] sum_shift;
  logic [7:0]  gray_d, gray_q;
  logic        gray_valid_q;

  // Position of the pixel currently presented on the output.
  logic [ColW-1:0] col_d, col_q;
  logic [RowW-1:0] row_d, row_q;
  logic            col_end, row_end;
  logic            frame_done_d, frame_done_q;

  assign adv         = !gray_valid_q || m_gray_ready;
  assign out_hs      = gray_valid_q && m_gray_ready;
  assign s_rgb_ready = adv;

  always_comb begin
    pr_d = KrC * 16'(s_rgb_data[23:16]);
    pg_d = KgC * 16'(s_rgb_data[15:8]);
    pb_d = KbC * 16'(s_rgb_data[7:0]);
  end

  always_comb begin
    sum_d     = 18'(pr_q) + 18'(pg_q) + 18'(pb_q) + RoundBias;
    sum_shift = sum_d >> 8;
    // Anything at or above 65536 before the shift would wrap; clamp it to white.
    gray_d    = (sum_shift > 18'd255) ? 8'hFF : sum_shift[7:0];
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      pr_q         <= '0;
      pg_q         <= '0;
      pb_q         <= '0;
      v1_q         <= 1'b0;
      gray_q       <= '0;
      gray_valid_q <= 1'b0;
    end else if (adv) begin
      pr_q         <= pr_d;
      pg_q         <= pg_d;
      pb_q         <= pb_d;
      v1_q         <= s_rgb_valid;
      gray_q       <= gray_d;
      gray_valid_q <= v1_q;
    end
  end

  assign col_end = (col_q == ColMax);
  assign row_end = (row_q == RowMax);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (out_hs) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  assign frame_done_d = out_hs && col_end && row_end;

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_gray_valid = gray_valid_q;
  assign m_gray_data  = gray_q;
  assign m_gray_eol   = gray_valid_q && col_end;
  assign m_gray_last  = gray_valid_q && col_end && row_end;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed-step bench for rgb_to_gray_stream with a queue scoreboard. The main instance
// uses a 4x2 frame. A second instance with all coefficients at 255 exercises saturation.
module tb_rgb_to_gray_stream;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic        axi_clk = 1'b0;
  logic        axi_rst_n = 1'b0;
  logic        s_rgb_valid = 1'b0;
  logic [23:0] s_rgb_data = '0;
  logic        s_rgb_ready;
  logic        m_gray_valid;
  logic [7:0]  m_gray_data;
  logic        m_gray_ready = 1'b1;
  logic        m_gray_eol;
  logic        m_gray_last;
  logic        frame_done;

  logic        sat_valid = 1'b0;
  logic [23:0] sat_data = '0;
  logic        sat_ready;
  logic        sat_gvalid;
  logic [7:0]  sat_gdata;
  logic        sat_eol;
  logic        sat_last;
  logic        sat_fd;

  always #5 axi_clk = ~axi_clk;

  rgb_to_gray_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_rgb_valid  (s_rgb_valid),
    .s_rgb_data   (s_rgb_data),
    .s_rgb_ready  (s_rgb_ready),
    .m_gray_valid (m_gray_valid),
    .m_gray_data  (m_gray_data),
    .m_gray_ready (m_gray_ready),
    .m_gray_eol   (m_gray_eol),
    .m_gray_last  (m_gray_last),
    .frame_done   (frame_done)
  );

  rgb_to_gray_stream #(.KR(255), .KG(255), .KB(255)) u_sat (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .s_rgb_valid  (sat_valid),
    .s_rgb_data   (sat_data),
    .s_rgb_ready  (sat_ready),
    .m_gray_valid (sat_gvalid),
    .m_gray_data  (sat_gdata),
    .m_gray_ready (1'b1),
    .m_gray_eol   (sat_eol),
    .m_gray_last  (sat_last),
    .frame_done   (sat_fd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rdy_toggle = 1'b0;
  bit rdy_level = 1'b1;
  logic [7:0] sb_q[$];

  int         out_cnt = 0;
  bit         prev_last = 1'b0;
  bit         held_v = 1'b0;
  logic [7:0] held_d;
  logic       held_e, held_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] luma(input logic [23:0] rgb);
    int s;
    s = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]);
`ifdef RGB2GRAY_ROUND_EN
    s = s + 128;
`endif
    s = s >> 8;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge axi_clk);
    #1;
    cyc++;
    m_gray_ready = rdy_toggle ? cyc[0] : rdy_level;
    #1;
  endtask

  task automatic send(input logic [23:0] rgb, input logic [7:0] exp);
    bit acc;
    int n;
    n = 0;
    s_rgb_data  = rgb;
    s_rgb_valid = 1'b1;
    do begin
      #1;
      acc = s_rgb_ready;
      if (acc) sb_q.push_back(exp);
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    s_rgb_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    axi_rst_n   = 1'b0;
    s_rgb_valid = 1'b0;
    sb_q.delete();
    repeat (2) tick();
    axi_rst_n = 1'b1;
    tick();
  endtask

  // Output monitor: scoreboard pop, eol/last/frame_done model, stall stability.
  always @(negedge axi_clk) begin
    if (!axi_rst_n) begin
      out_cnt   = 0;
      prev_last = 1'b0;
      held_v    = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(prev_last));
      check("eol", 32'(m_gray_eol), 32'(m_gray_valid && (out_cnt % W == W - 1)));
      check("last", 32'(m_gray_last), 32'(m_gray_valid && (out_cnt % (W * H) == W * H - 1)));
      if (held_v) begin
        check("stall_valid", 32'(m_gray_valid), 32'd1);
        check("stall_data", 32'(m_gray_data), 32'(held_d));
        check("stall_eol", 32'(m_gray_eol), 32'(held_e));
        check("stall_last", 32'(m_gray_last), 32'(held_l));
      end
      prev_last = 1'b0;
      if (m_gray_valid && m_gray_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          check("data", 32'(m_gray_data), 32'(sb_q.pop_front()));
        end
        prev_last = (out_cnt % (W * H) == W * H - 1);
        out_cnt++;
      end
      held_v = m_gray_valid && !m_gray_ready;
      held_d = m_gray_data;
      held_e = m_gray_eol;
      held_l = m_gray_last;
    end
  end

  initial begin
    // Reset state.
    #1;
    check("rst_valid", 32'(m_gray_valid), 32'd0);
    check("rst_data", 32'(m_gray_data), 32'd0);
    check("rst_eol", 32'(m_gray_eol), 32'd0);
    check("rst_last", 32'(m_gray_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(s_rgb_ready), 32'd1);
    check("rst_sat_ready", 32'(sat_ready), 32'd1);
    repeat (2) tick();
    axi_rst_n = 1'b1;
    tick();

    // Mid grey: exact for both builds; output appears on the second edge after acceptance.
    send(24'hC8C8C8, 8'd200);
    check("lat_not_yet", 32'(m_gray_valid), 32'd0);
    s_rgb_valid = 1'b0;
    tick();
    check("lat_valid", 32'(m_gray_valid), 32'd1);
    check("lat_data", 32'(m_gray_data), 32'd200);
    idle(3);

    // Primaries and white, back to back.
`ifdef RGB2GRAY_ROUND_EN
    send(24'hFF0000, 8'd77);
    send(24'h00FF00, 8'd149);
    send(24'h0000FF, 8'd29);
`else
    send(24'hFF0000, 8'd76);
    send(24'h00FF00, 8'd149);
    send(24'h0000FF, 8'd28);
`endif
    send(24'hFFFFFF, 8'd255);
    idle(4);

    // Sixteen greys, toggling ready, random input gaps.
    rdy_toggle = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = 8'(i * 17);
      idle(int'($urandom_range(0, 2)));
      send({v, v, v}, luma({v, v, v}));
    end
    s_rgb_valid = 1'b0;
    repeat (10) tick();
    rdy_toggle = 1'b0;
    idle(4);
    check("stream_drained", 32'(sb_q.size()), 32'd0);

    // A fresh 4x2 frame at full rate, then two pixels of the next frame.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      logic [23:0] px;
      px = {8'(i * 20), 8'(i * 7 + 3), 8'(255 - i * 11)};
      send(px, luma(px));
    end
    idle(5);
    check("frame_drained", 32'(sb_q.size()), 32'd0);

    // Fill both stages under stall, then reset asynchronously.
    rdy_level = 1'b0;
    idle(1);
    send(24'h102030, luma(24'h102030));
    send(24'h405060, luma(24'h405060));
    check("full_ready_low", 32'(s_rgb_ready), 32'd0);
    check("full_valid", 32'(m_gray_valid), 32'd1);
    axi_rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(m_gray_valid), 32'd0);
    check("arst_data", 32'(m_gray_data), 32'd0);
    check("arst_eol", 32'(m_gray_eol), 32'd0);
    check("arst_last", 32'(m_gray_last), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_ready", 32'(s_rgb_ready), 32'd1);
    sb_q.delete();
    s_rgb_valid = 1'b0;
    rdy_level = 1'b1;
    repeat (2) tick();
    axi_rst_n = 1'b1;
    tick();
    // Counting restarts at col 0: eol must land on the fourth pixel after reset.
    for (int i = 0; i < 4; i++) begin
      logic [23:0] px;
      px = {8'(i * 60), 8'(200 - i * 30), 8'(i * 5)};
      send(px, luma(px));
    end
    idle(5);
    check("post_reset_drained", 32'(sb_q.size()), 32'd0);
    check("post_reset_count", 32'(out_cnt), 32'd4);

    // Saturation: 3*255*255 overflows 16 bits and must clamp to 255.
    sat_data  = 24'hFFFFFF;
    sat_valid = 1'b1;
    tick();
    sat_valid = 1'b0;
    tick();
    check("sat_valid", 32'(sat_gvalid), 32'd1);
    check("sat_data", 32'(sat_gdata), 32'd255);
    check("sat_eol", 32'(sat_eol), 32'd0);
    check("sat_last", 32'(sat_last), 32'd0);
    check("sat_frame_done", 32'(sat_fd), 32'd0);
    tick();
    check("sat_empty", 32'(sat_gvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
